// File: rtl/i2c_resp_regs.sv
// I2C responder exposing a small control/GPIO register file to an external master.
// Oversamples SCL/SDA on bbc_ck8 and only ever pulls SDA low (open-drain).
//
// Ports:
//   bbc_ck8   in   system clock (8 MHz)
//   reset     in   asynchronous reset, active-high
//   scl_in    in   raw SCL pin level
//   sda_in    in   raw SDA pin level
//   sda_oe    out  1 = pull SDA low
//   gpio_in   in   raw GPIO pin levels
//   gpio_out  out  register 1
//   gpio_oe   out  register 2, 1 = drive
//   ctrl_q    out  register 0
//   busy      out  high from an addressed START until STOP or NACK
//
// Register map: 0 ctrl, 1 gpio_out, 2 gpio_oe, 3 synced gpio_in (RO), 4 ID_BYTE (RO),
// 5-7 read 0. The pointer auto-increments and persists across transactions.
module i2c_resp_regs #(
  parameter logic [6:0]  I2C_ADDR = 7'h2A,
  parameter int unsigned GPIO_SZ  = 7,
  parameter logic [7:0]  ID_BYTE  = 8'hB8
) (
  input  logic               bbc_ck8,
  input  logic               reset,
  input  logic               scl_in,
  input  logic               sda_in,
  output logic               sda_oe,
  input  logic [GPIO_SZ-1:0] gpio_in,
  output logic [GPIO_SZ-1:0] gpio_out,
  output logic [GPIO_SZ-1:0] gpio_oe,
  output logic [7:0]         ctrl_q,
  output logic               busy
);

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck
  } state_e;

  // [0] first stage, [1] synchronized value, [2] history for edge detection
  logic [2:0]         scl_sync_q, sda_sync_q;
  logic [GPIO_SZ-1:0] gpio_meta_q, gpio_sync_q;

  always_ff @(posedge bbc_ck8 or posedge reset) begin
    if (reset) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      gpio_meta_q <= '1;
      gpio_sync_q <= '1;
    end else begin
      scl_sync_q  <= {scl_sync_q[1:0], scl_in};
      sda_sync_q  <= {sda_sync_q[1:0], sda_in};
      gpio_meta_q <= gpio_in;
      gpio_sync_q <= gpio_meta_q;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det, sda_bit;

  assign sda_bit   = sda_sync_q[1];
  assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
  assign start_det = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[2] & ~sda_sync_q[1];
  assign stop_det  = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[2] & sda_sync_q[1];

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         ptr_q, ptr_d;
  logic               sda_oe_q, sda_oe_d;
  logic               busy_q, busy_d;
  logic               rw_q, rw_d;
  logic               wr_pend_q, wr_pend_d;
  logic [7:0]         ctrl_d;
  logic [GPIO_SZ-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_SZ-1:0] gpio_oe_q, gpio_oe_d;
  logic [7:0]         rd_data;

  always_ff @(posedge bbc_ck8 or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      wr_pend_q  <= 1'b0;
      ctrl_q     <= '0;
      gpio_out_q <= '0;
      gpio_oe_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      wr_pend_q  <= wr_pend_d;
      ctrl_q     <= ctrl_d;
      gpio_out_q <= gpio_out_d;
      gpio_oe_q  <= gpio_oe_d;
    end
  end

  // Read mux; narrow registers are zero-extended.
  always_comb begin
    rd_data = '0;
    case (ptr_q)
      3'd0:    rd_data = ctrl_q;
      3'd1:    rd_data[GPIO_SZ-1:0] = gpio_out_q;
      3'd2:    rd_data[GPIO_SZ-1:0] = gpio_oe_q;
      3'd3:    rd_data[GPIO_SZ-1:0] = gpio_sync_q;
      3'd4:    rd_data = ID_BYTE;
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    wr_pend_d  = 1'b0;
    ctrl_d     = ctrl_q;
    gpio_out_d = gpio_out_q;
    gpio_oe_d  = gpio_oe_q;

    // Register write lands one cycle after the 8th data bit, when shift_q holds the byte.
    if (wr_pend_q) begin
      case (ptr_q)
        3'd0:    ctrl_d = shift_q;
        3'd1:    gpio_out_d = shift_q[GPIO_SZ-1:0];
        3'd2:    gpio_oe_d = shift_q[GPIO_SZ-1:0];
        default: ;
      endcase
      ptr_d = ptr_q + 3'd1;
    end

    if (start_det) begin
      state_d  = StAddr;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_bit};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = '0;
              case (state_q)
                StAddr: begin
                  if (shift_d[7:1] == I2C_ADDR) begin
                    state_d = StAddrAck;
                    busy_d  = 1'b1;
                    rw_d    = sda_bit;
                  end else begin
                    state_d = StIdle;
                  end
                end
                StPtr: begin
                  ptr_d   = shift_d[2:0];
                  state_d = StPtrAck;
                end
                default: begin
                  wr_pend_d = 1'b1;
                  state_d   = StWdataAck;
                end
              endcase
            end
          end
        end

        // First fall after bit 8 asserts the ACK, the fall after bit 9 ends it.
        StAddrAck, StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              if (state_q == StAddrAck && rw_q) begin
                shift_d  = rd_data;
                ptr_d    = ptr_q + 3'd1;
                sda_oe_d = ~rd_data[7];
                state_d  = StRdata;
              end else if (state_q == StAddrAck) begin
                state_d = StPtr;
              end else begin
                state_d = StWdata;
              end
            end
          end
        end

        // Bit 7 is already on the wire at entry; each fall presents the next bit.
        StRdata: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = StRdataAck;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end

        // cnt_q == 1 marks "master ACKed, next byte due on the coming fall".
        StRdataAck: begin
          if (scl_rise) begin
            if (sda_bit) begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end else begin
              cnt_d = 4'd1;
            end
          end else if (scl_fall && cnt_q == 4'd1) begin
            shift_d  = rd_data;
            ptr_d    = ptr_q + 3'd1;
            sda_oe_d = ~rd_data[7];
            cnt_d    = '0;
            state_d  = StRdata;
          end
        end

        default: ;
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign gpio_out = gpio_out_q;
  assign gpio_oe  = gpio_oe_q;

endmodule

// File: tb/tb_i2c_resp_regs.sv
// Self-checking bench for i2c_resp_regs: bit-banged I2C master on an open-drain SDA model,
// register-file reference model, randomized write/read transactions.
module tb_i2c_resp_regs;

  localparam logic [6:0] Addr   = 7'h2A;
  localparam logic [7:0] IdByte = 8'hB8;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       tb_sda_low;
  logic       sda_line;
  logic       sda_oe;
  logic [6:0] gpio_in, gpio_out, gpio_oe;
  logic [7:0] ctrl_q;
  logic       busy;

  assign sda_line = ~(tb_sda_low | sda_oe);

  i2c_resp_regs dut (
    .bbc_ck8  (clk),
    .reset    (reset),
    .scl_in   (scl),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .ctrl_q   (ctrl_q),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Monitors: cycle count, sda_oe high count, clocks from SCL fall to each sda_oe change.
  int unsigned cyc = 0;
  int unsigned fall_cyc = 0;
  int unsigned oe_hi_cnt = 0;
  int unsigned hold_q[$];
  logic        oe_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sda_oe === 1'b1) oe_hi_cnt <= oe_hi_cnt + 1;
    if (sda_oe !== oe_prev) hold_q.push_back(cyc - fall_cyc);
    oe_prev <= sda_oe;
  end

  // Reference model
  logic [7:0] m_reg[3];
  logic [2:0] m_ptr;

  function automatic logic [7:0] m_read(input logic [2:0] p);
    if (p < 3'd3) return m_reg[int'(p)];
    if (p == 3'd3) return {1'b0, gpio_in};
    if (p == 3'd4) return IdByte;
    return 8'h00;
  endfunction

  logic [7:0] tx_buf[16];
  int         tx_len;
  logic       ack_buf[16];
  logic [7:0] rx_buf[16];
  logic       busy_at_ack, busy_at_end, busy_after, oe_after_nack, busy_after_nack;

  // Applies an addressed write transaction (tx_buf[0] is the pointer byte).
  task automatic m_write_txn();
    m_ptr = tx_buf[0][2:0];
    for (int i = 1; i < tx_len; i++) begin
      if (m_ptr == 3'd0) m_reg[0] = tx_buf[i];
      else if (m_ptr < 3'd3) m_reg[int'(m_ptr)] = tx_buf[i] & 8'h7F;
      m_ptr = m_ptr + 3'd1;
    end
  endtask

  // Bit-level master
  int q = 200;

  task automatic set_scl(input logic v);
    scl = v;
    if (!v) fall_cyc = cyc;
  endtask

  task automatic bus_start();
    tb_sda_low = 1'b0; #q;
    set_scl(1'b1); #q;
    tb_sda_low = 1'b1; #q;
    set_scl(1'b0); #q;
  endtask

  task automatic bus_stop();
    tb_sda_low = 1'b1; #q;
    set_scl(1'b1); #q;
    tb_sda_low = 1'b0; #q;
    #q;
  endtask

  task automatic write_bit(input logic b);
    tb_sda_low = ~b; #q;
    set_scl(1'b1); #(2 * q);
    set_scl(1'b0); #q;
  endtask

  task automatic read_bit(output logic b);
    tb_sda_low = 1'b0; #q;
    set_scl(1'b1); #q;
    b = sda_line; #q;
    set_scl(1'b0); #q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic do_write(input logic [7:0] addr_byte);
    logic a;
    bus_start();
    write_byte(addr_byte, a);
    ack_buf[0]  = a;
    busy_at_ack = busy;
    for (int i = 0; i < tx_len; i++) begin
      write_byte(tx_buf[i], a);
      ack_buf[i + 1] = a;
    end
    busy_at_end = busy;
    bus_stop();
    busy_after = busy;
  endtask

  // Optional pointer write then repeated START into a read of n bytes (last one NACKed).
  task automatic do_read(input logic set_ptr, input logic [2:0] ptr, input int n);
    logic       a;
    logic [7:0] d;
    bus_start();
    if (set_ptr) begin
      write_byte({Addr, 1'b0}, a);
      ack_buf[0] = a;
      write_byte({5'b0, ptr}, a);
      ack_buf[1] = a;
      bus_start();
    end
    write_byte({Addr, 1'b1}, a);
    ack_buf[2] = a;
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      rx_buf[i] = d;
    end
    oe_after_nack   = sda_oe;
    busy_after_nack = busy;
    bus_stop();
  endtask

  task automatic test_reset();
    logic [7:0] a_byte;
    reset = 1'b1; scl = 1'b1; tb_sda_low = 1'b0; gpio_in = '0;
    #20;
    n_checks++; if (sda_oe !== 1'b0) $display("FAIL por_sda_oe: got %b want 0", sda_oe); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL por_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (ctrl_q !== 8'h00) $display("FAIL por_ctrl: got %h want 00", ctrl_q); else n_pass++;
    n_checks++; if (gpio_out !== 7'h00) $display("FAIL por_gpio_out: got %h want 00", gpio_out);
    else n_pass++;
    n_checks++; if (gpio_oe !== 7'h00) $display("FAIL por_gpio_oe: got %h want 00", gpio_oe);
    else n_pass++;
    reset = 1'b0;
    #100;
    m_reg[0] = '0; m_reg[1] = '0; m_reg[2] = '0; m_ptr = '0;
    q = 200;
    tx_buf[0] = 8'h00; tx_buf[1] = 8'h5A; tx_buf[2] = 8'h33; tx_buf[3] = 8'h0F; tx_len = 4;
    do_write({Addr, 1'b0});
    m_write_txn();
    n_checks++; if (gpio_oe !== m_reg[2][6:0])
      $display("FAIL pre_reset_gpio_oe: got %h want %h", gpio_oe, m_reg[2][6:0]); else n_pass++;
    // Hit reset while the responder holds the address ACK.
    a_byte = {Addr, 1'b0};
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(a_byte[i]);
    #q;
    n_checks++; if (sda_oe !== 1'b1) $display("FAIL mid_ack_sda_oe: got %b want 1", sda_oe);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (sda_oe !== 1'b0) $display("FAIL rst_sda_oe: got %b want 0", sda_oe); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (ctrl_q !== 8'h00) $display("FAIL rst_ctrl: got %h want 00", ctrl_q); else n_pass++;
    n_checks++; if (gpio_oe !== 7'h00) $display("FAIL rst_gpio_oe: got %h want 00", gpio_oe);
    else n_pass++;
    #9;
    reset = 1'b0;
    tb_sda_low = 1'b0;
    set_scl(1'b1);
    #(4 * q);
    m_reg[0] = '0; m_reg[1] = '0; m_reg[2] = '0; m_ptr = '0;
  endtask

  task automatic test_write_burst();
    q = 200;
    tx_buf[0] = 8'h00; tx_buf[1] = 8'hA5; tx_buf[2] = 8'h7F; tx_len = 3;
    do_write({Addr, 1'b0});
    m_write_txn();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (ack_buf[i] !== 1'b0) $display("FAIL burst_ack%0d: got %b want 0", i, ack_buf[i]);
      else n_pass++;
    end
    n_checks++; if (ctrl_q !== m_reg[0]) $display("FAIL burst_ctrl: got %h want %h", ctrl_q, m_reg[0]);
    else n_pass++;
    n_checks++; if (gpio_out !== m_reg[1][6:0])
      $display("FAIL burst_gpio_out: got %h want %h", gpio_out, m_reg[1][6:0]); else n_pass++;
    n_checks++; if (busy_at_ack !== 1'b1) $display("FAIL burst_busy_ack: got %b want 1", busy_at_ack);
    else n_pass++;
    n_checks++; if (busy_at_end !== 1'b1) $display("FAIL burst_busy_end: got %b want 1", busy_at_end);
    else n_pass++;
    n_checks++; if (busy_after !== 1'b0) $display("FAIL burst_busy_stop: got %b want 0", busy_after);
    else n_pass++;
  endtask

  task automatic test_rs_read();
    logic [7:0] exp_b[2];
    q = 200;
    gpio_in = 7'h15;
    #100;
    m_ptr = 3'd3;
    for (int i = 0; i < 2; i++) begin
      exp_b[i] = m_read(m_ptr);
      m_ptr = m_ptr + 3'd1;
    end
    do_read(1'b1, 3'd3, 2);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (ack_buf[i] !== 1'b0) $display("FAIL rs_ack%0d: got %b want 0", i, ack_buf[i]);
      else n_pass++;
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (rx_buf[i] !== exp_b[i])
        $display("FAIL rs_byte%0d: got %h want %h", i, rx_buf[i], exp_b[i]); else n_pass++;
    end
    n_checks++; if (oe_after_nack !== 1'b0) $display("FAIL rs_sda_nack: got %b want 0", oe_after_nack);
    else n_pass++;
    n_checks++; if (busy_after_nack !== 1'b0)
      $display("FAIL rs_busy_nack: got %b want 0", busy_after_nack); else n_pass++;
  endtask

  task automatic test_foreign();
    int unsigned oe_snap;
    q = 50;
    oe_snap = oe_hi_cnt;
    tx_buf[0] = 8'h01; tx_len = 1;
    do_write(8'h56);
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (ack_buf[i] !== 1'b1) $display("FAIL foreign_nack%0d: got %b want 1", i, ack_buf[i]);
      else n_pass++;
    end
    n_checks++; if (oe_hi_cnt !== oe_snap)
      $display("FAIL foreign_oe: got %0d want %0d", oe_hi_cnt, oe_snap); else n_pass++;
    n_checks++; if (busy_at_ack !== 1'b0) $display("FAIL foreign_busy: got %b want 0", busy_at_ack);
    else n_pass++;
    n_checks++; if (ctrl_q !== m_reg[0]) $display("FAIL foreign_ctrl: got %h want %h", ctrl_q, m_reg[0]);
    else n_pass++;
    n_checks++; if (gpio_out !== m_reg[1][6:0])
      $display("FAIL foreign_gpio_out: got %h want %h", gpio_out, m_reg[1][6:0]); else n_pass++;
  endtask

  task automatic test_ptr_wrap();
    q = 50;
    tx_buf[0] = 8'h07; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_len = 3;
    do_write({Addr, 1'b0});
    m_write_txn();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (ack_buf[i] !== 1'b0) $display("FAIL wrap_ack%0d: got %b want 0", i, ack_buf[i]);
      else n_pass++;
    end
    n_checks++; if (ctrl_q !== m_reg[0]) $display("FAIL wrap_ctrl: got %h want %h", ctrl_q, m_reg[0]);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic        a;
    int          idx;
    int unsigned mn;
    logic [7:0]  nib;
    q = 200;
    nib = 8'($urandom_range(0, 15));
    bus_start();
    write_byte({Addr, 1'b0}, a);
    n_checks++; if (a !== 1'b0) $display("FAIL abort_addr_ack: got %b want 0", a); else n_pass++;
    write_byte(8'h00, a);
    n_checks++; if (a !== 1'b0) $display("FAIL abort_ptr_ack: got %b want 0", a); else n_pass++;
    m_ptr = 3'd0;
    for (int i = 3; i >= 0; i--) write_bit(nib[i]);
    bus_stop();
    n_checks++; if (ctrl_q !== m_reg[0]) $display("FAIL abort_ctrl: got %h want %h", ctrl_q, m_reg[0]);
    else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
    q = 50;
    idx = hold_q.size();
    tx_buf[0] = 8'h00; tx_buf[1] = 8'($urandom_range(0, 255)); tx_len = 2;
    do_write({Addr, 1'b0});
    m_write_txn();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (ack_buf[i] !== 1'b0) $display("FAIL fast_ack%0d: got %b want 0", i, ack_buf[i]);
      else n_pass++;
    end
    n_checks++; if (ctrl_q !== m_reg[0]) $display("FAIL fast_ctrl: got %h want %h", ctrl_q, m_reg[0]);
    else n_pass++;
    mn = 1000;
    for (int i = idx; i < hold_q.size(); i++) if (hold_q[i] < mn) mn = hold_q[i];
    n_checks++; if (!(hold_q.size() > idx && mn >= 2))
      $display("FAIL fast_hold: got %0d clocks want >= 2", mn); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] exp_b[4];
    int         n;
    logic [2:0] p;
    logic       set_ptr;
    q = 50;
    for (int it = 0; it < 6; it++) begin
      tx_len = 1 + int'($urandom_range(1, 3));
      tx_buf[0] = 8'($urandom_range(0, 255));
      for (int i = 1; i < tx_len; i++) tx_buf[i] = 8'($urandom_range(0, 255));
      do_write({Addr, 1'b0});
      m_write_txn();
      for (int i = 0; i <= tx_len; i++) begin
        n_checks++; if (ack_buf[i] !== 1'b0)
          $display("FAIL rnd%0d_wack%0d: got %b want 0", it, i, ack_buf[i]); else n_pass++;
      end
      n_checks++; if ({ctrl_q, gpio_out, gpio_oe} !== {m_reg[0], m_reg[1][6:0], m_reg[2][6:0]})
        $display("FAIL rnd%0d_regs: got %h/%h/%h want %h/%h/%h", it, ctrl_q, gpio_out, gpio_oe,
                 m_reg[0], m_reg[1][6:0], m_reg[2][6:0]);
      else n_pass++;
      gpio_in = 7'($urandom_range(0, 127));
      #100;
      set_ptr = it[0];
      p = 3'($urandom_range(0, 7));
      n = int'($urandom_range(1, 4));
      if (set_ptr) m_ptr = p;
      for (int i = 0; i < n; i++) begin
        exp_b[i] = m_read(m_ptr);
        m_ptr = m_ptr + 3'd1;
      end
      do_read(set_ptr, p, n);
      n_checks++; if (ack_buf[2] !== 1'b0) $display("FAIL rnd%0d_rack: got %b want 0", it, ack_buf[2]);
      else n_pass++;
      for (int i = 0; i < n; i++) begin
        n_checks++; if (rx_buf[i] !== exp_b[i])
          $display("FAIL rnd%0d_byte%0d: got %h want %h", it, i, rx_buf[i], exp_b[i]); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_rs_read();
    test_foreign();
    test_ptr_wrap();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
